// File: rtl/otbn_bignum_mul_seq.sv
// otbn_bignum_mul_seq
//
// Sequencer sitting directly upstream of the OTBN bignum MAC. A start
// handshake kicks off a full 256x256-bit unsigned multiply. The block issues
// the fixed 16-step MULQACC schedule, one 64x64 quarter-word product per
// issued step. It collects the four 128-bit half-words that the MAC shifts out
// of its accumulator and presents the 512-bit product with a one-cycle done
// pulse.
//
// Ports
//   clk_i            in   1    clock
//   rst_ni           in   1    asynchronous active-low reset
//   start_i          in   1    start request, accepted only while ready_o=1
//   op_a_i           in   256  multiplicand A
//   op_b_i           in   256  multiplicand B
//   stall_i          in   1    hold the sequence, no MAC op issued this cycle
//   cancel_i         in   1    abort the sequence (highest priority input)
//   ready_o          out  1    high in IDLE
//   busy_o           out  1    high in RUN
//   done_o           out  1    one-cycle pulse, result_o valid in that cycle
//   result_o         out  512  product A*B
//   mac_operation_o  out  521  MAC operation (mac_bignum_operation_t, packed)
//   mac_en_o         out  1    MAC enable
//   mac_result_i     in   256  MAC adder output for the current operation
//
// mac_operation_o packing, MSB first, matches mac_bignum_operation_t:
//   [520:265] operand_a, [264:9] operand_b, [8:7] operand_a_qw_sel,
//   [6:5] operand_b_qw_sel, [4] wr_hw_sel_upper, [3:2] pre_acc_shift_imm,
//   [1] zero_acc, [0] shift_acc
//
// Build option OTBN_BIGNUM_MUL_SEQ_OPREG_EN: when defined, op_a_i/op_b_i are
// captured on the accepted start so the source may change them afterwards.
// When undefined, the operands pass straight through and the source must hold
// them stable until done_o.

module otbn_bignum_mul_seq (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [255:0]   op_a_i,
  input  logic [255:0]   op_b_i,
  input  logic           stall_i,
  input  logic           cancel_i,
  output logic           ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [511:0]   result_o,
  output logic [520:0]   mac_operation_o,
  output logic           mac_en_o,
  input  logic [255:0]   mac_result_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       r_state;
  state_e       w_stateNext;
  logic [3:0]   r_step;
  logic [511:0] r_result;
  logic [8:0]   w_ctrl;
  logic [1:0]   w_capIdx;
  logic         w_start;
  logic         w_issue;
  logic [255:0] w_opA;
  logic [255:0] w_opB;
  logic         w_unusedMacHi;

  // Cancel outranks start, so a start in the same cycle as cancel is dropped.
  assign w_start = (r_state == ST_IDLE) & start_i & ~cancel_i;
  assign w_issue = (r_state == ST_RUN) & ~stall_i & ~cancel_i;

  // Only the low half of the adder output is ever captured; the upper half
  // stays inside the MAC accumulator.
  assign w_unusedMacHi = ^mac_result_i[255:128];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. RUN leaves only once step 15 has actually been issued.
  always_comb begin
    w_stateNext = r_state;
    if (cancel_i) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) w_stateNext = ST_RUN;
        ST_RUN:  if (!stall_i && (r_step == 4'd15)) w_stateNext = ST_DONE;
        ST_DONE: w_stateNext = ST_IDLE;
        default: w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Output logic. The MAC operation is all-zero outside RUN so the MAC sees a
  // quiet bus whenever the sequencer is not driving a multiply.
  always_comb begin
    ready_o         = (r_state == ST_IDLE);
    busy_o          = (r_state == ST_RUN);
    done_o          = (r_state == ST_DONE);
    mac_en_o        = w_issue;
    mac_operation_o = '0;
    if (r_state == ST_RUN) begin
      mac_operation_o = {w_opA, w_opB, w_ctrl};
    end
  end

  // MULQACC schedule. Each entry is
  // {a_qw_sel, b_qw_sel, wr_hw_sel_upper, shift_imm, zero_acc, shift_acc}.
  // Steps are grouped by product weight; the four shift_acc steps close out a
  // 128-bit column and hand its low half to the result register.
  always_comb begin
    w_ctrl = '0;
    case (r_step)
      4'd0:  w_ctrl = {2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0};
      4'd1:  w_ctrl = {2'd1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0};
      4'd2:  w_ctrl = {2'd0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1};
      4'd3:  w_ctrl = {2'd2, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
      4'd4:  w_ctrl = {2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0};
      4'd5:  w_ctrl = {2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0};
      4'd6:  w_ctrl = {2'd3, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0};
      4'd7:  w_ctrl = {2'd2, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0};
      4'd8:  w_ctrl = {2'd1, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0};
      4'd9:  w_ctrl = {2'd0, 2'd3, 1'b1, 2'd1, 1'b0, 1'b1};
      4'd10: w_ctrl = {2'd3, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0};
      4'd11: w_ctrl = {2'd2, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0};
      4'd12: w_ctrl = {2'd1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0};
      4'd13: w_ctrl = {2'd3, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0};
      4'd14: w_ctrl = {2'd2, 2'd3, 1'b0, 2'd1, 1'b0, 1'b1};
      4'd15: w_ctrl = {2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1};
      default: w_ctrl = '0;
    endcase
  end

  // Result half-word written by each capture step.
  always_comb begin
    w_capIdx = 2'd0;
    case (r_step)
      4'd9:    w_capIdx = 2'd1;
      4'd14:   w_capIdx = 2'd2;
      4'd15:   w_capIdx = 2'd3;
      default: w_capIdx = 2'd0;
    endcase
  end

  // Step counter advances only on issued steps, so stalls simply stretch RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_step <= 4'd0;
    end else if (w_start || cancel_i) begin
      r_step <= 4'd0;
    end else if (w_issue) begin
      r_step <= r_step + 4'd1;
    end
  end

  // Product register: cleared on start and cancel, filled one half-word per
  // capture step from the low 128 bits of the MAC adder output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
    end else if (w_start || cancel_i) begin
      r_result <= '0;
    end else if (w_issue && w_ctrl[0]) begin
      r_result[128*w_capIdx +: 128] <= mac_result_i[127:0];
    end
  end

  assign result_o = r_result;

`ifdef OTBN_BIGNUM_MUL_SEQ_OPREG_EN
  logic [255:0] r_opA;
  logic [255:0] r_opB;

  // Operand snapshot taken on the accepted start frees the source afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opA <= '0;
      r_opB <= '0;
    end else if (w_start) begin
      r_opA <= op_a_i;
      r_opB <= op_b_i;
    end
  end

  assign w_opA = r_opA;
  assign w_opB = r_opB;
`else
  assign w_opA = op_a_i;
  assign w_opB = op_b_i;
`endif

endmodule

// File: tb/tb_otbn_bignum_mul_seq.sv
// Testbench for otbn_bignum_mul_seq. A behavioural OTBN bignum MAC is attached
// to the sequencer, and every finished multiply is compared against plain
// 512-bit A*B arithmetic. Per-cycle handshake, enable and flag expectations
// come from the bench's own count of issued steps.

module tb_otbn_bignum_mul_seq;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [255:0] op_a_i;
  logic [255:0] op_b_i;
  logic         stall_i;
  logic         cancel_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [511:0] result_o;
  logic [520:0] mac_operation_o;
  logic         mac_en_o;
  logic [255:0] mac_result_i;

  int checkCount = 0;
  int failCount  = 0;

  logic [255:0] holdA;
  logic [255:0] holdB;

  always #5 clk_i = ~clk_i;

  otbn_bignum_mul_seq dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .op_a_i          (op_a_i),
    .op_b_i          (op_b_i),
    .stall_i         (stall_i),
    .cancel_i        (cancel_i),
    .ready_o         (ready_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .mac_operation_o (mac_operation_o),
    .mac_en_o        (mac_en_o),
    .mac_result_i    (mac_result_i)
  );

  // Behavioural MAC: quarter-word product, pre-shift, accumulate, and an
  // optional 128-bit shift-out of the accumulator after the operation.
  logic [255:0] opAField;
  logic [255:0] opBField;
  logic [1:0]   aSel;
  logic [1:0]   bSel;
  logic [1:0]   shImm;
  logic         zeroAcc;
  logic         shiftAcc;
  logic [63:0]  macAQw;
  logic [63:0]  macBQw;
  logic [127:0] macProd;
  logic [255:0] macAddend;
  logic [255:0] macResult;
  logic [255:0] macAcc;

  assign opAField = mac_operation_o[520:265];
  assign opBField = mac_operation_o[264:9];
  assign aSel     = mac_operation_o[8:7];
  assign bSel     = mac_operation_o[6:5];
  assign shImm    = mac_operation_o[3:2];
  assign zeroAcc  = mac_operation_o[1];
  assign shiftAcc = mac_operation_o[0];

  always_comb begin
    macAQw    = opAField[64*aSel +: 64];
    macBQw    = opBField[64*bSel +: 64];
    macProd   = {64'b0, macAQw} * {64'b0, macBQw};
    macAddend = {128'b0, macProd} << (64*shImm);
    macResult = (zeroAcc ? 256'b0 : macAcc) + macAddend;
  end

  assign mac_result_i = macResult;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      macAcc <= '0;
    end else if (mac_en_o) begin
      macAcc <= shiftAcc ? {128'b0, macResult[255:128]} : macResult;
    end
  end

`ifndef OTBN_BIGNUM_MUL_SEQ_OPREG_EN
  // Pass-through operands must not move while the multiply is running.
  always @(negedge clk_i) begin
    if (busy_o === 1'b1) begin
      assert (op_a_i == holdA && op_b_i == holdB)
        else $error("[TB] operands changed while busy");
    end
  end
`endif

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".ready"}, ready_o, 1'b1);
    checkOutput({tag, ".busy"}, busy_o, 1'b0);
    checkOutput({tag, ".done"}, done_o, 1'b0);
    checkOutput({tag, ".macEn"}, mac_en_o, 1'b0);
    checkOutput({tag, ".macOp"}, mac_operation_o, 521'b0);
  endtask

  function automatic logic [255:0] randWord();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // One multiply. Step arguments are issue indices (-1 disables the event).
  // Called at just after a falling edge of an IDLE cycle.
  task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b,
                               input int stallStepA, input int stallLenA,
                               input int stallStepB, input int stallLenB,
                               input int cancelStep, input int resetStep,
                               input int pokeStep);
    logic [511:0] expected;
    int  issued;
    int  stallLeft;
    bit  stalledA;
    bit  stalledB;
    bit  doneSeen;
    bit  aborted;
    bit  expectIssue;

    expected  = {256'b0, a} * {256'b0, b};
    issued    = 0;
    stallLeft = 0;
    stalledA  = 1'b0;
    stalledB  = 1'b0;
    doneSeen  = 1'b0;
    aborted   = 1'b0;

    op_a_i   = a;
    op_b_i   = b;
    holdA    = a;
    holdB    = b;
    start_i  = 1'b1;
    stall_i  = 1'b0;
    cancel_i = 1'b0;
    #1;
    checkOutput("readyAtStart", ready_o, 1'b1);
    @(negedge clk_i);

    for (int cyc = 1; cyc <= 60 && !doneSeen && !aborted; cyc++) begin
`ifdef OTBN_BIGNUM_MUL_SEQ_OPREG_EN
      op_a_i = randWord();
      op_b_i = randWord();
`endif
      start_i  = 1'b0;
      stall_i  = 1'b0;
      cancel_i = 1'b0;
      if (issued < 16) begin
        if (issued == stallStepA && !stalledA) begin
          stallLeft = stallLenA;
          stalledA  = 1'b1;
        end
        if (issued == stallStepB && !stalledB) begin
          stallLeft = stallLenB;
          stalledB  = 1'b1;
        end
        if (stallLeft > 0) begin
          stall_i = 1'b1;
          stallLeft--;
        end
        if (issued == cancelStep) cancel_i = 1'b1;
        if (issued == pokeStep) start_i = 1'b1;
      end

      if (issued < 16 && issued == resetStep) begin
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        #1;
        checkIdle("midReset");
        checkOutput("midReset.result", result_o, 512'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checkIdle("afterReset");
        checkOutput("afterReset.result", result_o, 512'b0);
        aborted = 1'b1;
      end else begin
        #1;
        if (issued < 16) begin
          expectIssue = !(stall_i || cancel_i);
          checkOutput("run.busy", busy_o, 1'b1);
          checkOutput("run.ready", ready_o, 1'b0);
          checkOutput("run.done", done_o, 1'b0);
          checkOutput("run.macEn", mac_en_o, expectIssue);
          if (cyc == 1) checkOutput("resultClearedOnStart", result_o, 512'b0);
          if (expectIssue) begin
            checkOutput("zeroAcc", zeroAcc, issued == 0);
            checkOutput("shiftAcc", shiftAcc,
                        issued == 2 || issued == 9 || issued == 14 || issued == 15);
            checkOutput("operandA", opAField, a);
            checkOutput("operandB", opBField, b);
            issued++;
          end
          if (cancel_i) begin
            @(negedge clk_i);
            cancel_i = 1'b0;
            #1;
            checkIdle("afterCancel");
            checkOutput("afterCancel.result", result_o, 512'b0);
            aborted = 1'b1;
          end
        end else begin
          checkOutput("done.pulse", done_o, 1'b1);
          checkOutput("done.busy", busy_o, 1'b0);
          checkOutput("done.ready", ready_o, 1'b0);
          checkOutput("done.macEn", mac_en_o, 1'b0);
          checkOutput("done.macOp", mac_operation_o, 521'b0);
          checkOutput("product", result_o, expected);
          doneSeen = 1'b1;
        end
      end
      if (!aborted) @(negedge clk_i);
    end

    if (!doneSeen && !aborted) begin
      checkOutput("timeout", 1'b0, 1'b1);
    end else if (doneSeen) begin
      #1;
      checkIdle("afterDone");
      checkOutput("resultHeld", result_o, expected);
    end
  endtask

  initial begin
    rst_ni   = 1'b1;
    start_i  = 1'b0;
    stall_i  = 1'b0;
    cancel_i = 1'b0;
    op_a_i   = '0;
    op_b_i   = '0;
    holdA    = '0;
    holdB    = '0;
    #2;
    rst_ni = 1'b0;
    #1;
    checkIdle("reset");
    checkOutput("reset.result", result_o, 512'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;

    $display("[TB] basic products");
    applyStimulus(256'd1, 256'd1, -1, 0, -1, 0, -1, -1, -1);
    applyStimulus({256{1'b1}}, {256{1'b1}}, -1, 0, -1, 0, -1, -1, -1);
    applyStimulus(256'd1 << 192, (256'd1 << 192) + 256'd5, -1, 0, -1, 0, -1, -1, 5);

    $display("[TB] stalls");
    applyStimulus((256'd1 << 255) + 256'd3, (256'd1 << 255) + 256'd3, 4, 2, 12, 1, -1, -1, -1);

    $display("[TB] idle-side inputs");
    start_i  = 1'b1;
    cancel_i = 1'b1;
    stall_i  = 1'b1;
    #1;
    checkOutput("idleStall.macEn", mac_en_o, 1'b0);
    @(negedge clk_i);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    stall_i  = 1'b0;
    #1;
    checkIdle("startWithCancel");
    checkOutput("cancelClearsResult", result_o, 512'b0);

    $display("[TB] cancel and reset mid-sequence");
    applyStimulus(randWord(), randWord(), -1, 0, -1, 0, 8, -1, -1);
    applyStimulus(256'd7, 256'd6, -1, 0, -1, 0, -1, -1, -1);
    applyStimulus(randWord(), randWord(), -1, 0, -1, 0, -1, 10, -1);
    applyStimulus(256'd1 << 128, 256'd1 << 128, -1, 0, -1, 0, -1, -1, -1);

    $display("[TB] random operands");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(randWord(), randWord(),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
